// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: arbitrates redirect (irq/ret/call/branch) and stall
// requests for the program counter. It owns the hardware return-address
// stack and times the flush window that follows every redirect.
module pc_redirect_ctrl #(
  parameter int unsigned            ADDR_W    = 13,
  parameter int unsigned            RS_DEPTH  = 16,
  parameter logic [ADDR_W-1:0]      IRQ_VEC   = 13'h1FF0,
  parameter int unsigned            FLUSH_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_req_i,
  input  logic              br_req_i,
  input  logic [ADDR_W-1:0] br_addr_i,
  input  logic              call_req_i,
  input  logic [ADDR_W-1:0] call_addr_i,
  input  logic [ADDR_W-1:0] ret_addr_i,
  input  logic              ret_req_i,
  input  logic              irq_req_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic              jump_flag_o,
  output logic              call_en_o,
  output logic              hold_flag_o,
  output logic              flush_o,
  output logic              req_ack_o,
  output logic              irq_ack_o,
  output logic              in_isr_o,
  output logic              rs_empty_o,
  output logic              rs_full_o,
  output logic              rs_err_o
);

  // Stack pointer counts entries 0..RS_DEPTH, so it needs one bit more
  // than the entry index.
  localparam int unsigned IDX_W = $clog2(RS_DEPTH);
  localparam int unsigned SP_W  = IDX_W + 1;
  localparam int unsigned CNT_W = $clog2(FLUSH_CYC + 1);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // ---------------------------------------------------------------------
  // Registered state and outputs
  // ---------------------------------------------------------------------
  state_e            state_q,     state_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic [SP_W-1:0]   sp_q,        sp_d;
  logic [ADDR_W-1:0] jump_addr_q, jump_addr_d;
  logic              jump_flag_q, jump_flag_d;
  logic              call_en_q,   call_en_d;
  logic              hold_q,      hold_d;
  logic              flush_q,     flush_d;
  logic              req_ack_q,   req_ack_d;
  logic              irq_ack_q,   irq_ack_d;
  logic              in_isr_q,    in_isr_d;
  logic              err_q,       err_d;
  logic              empty_q,     full_q;

  // Return-address stack storage
  logic [ADDR_W-1:0] stack_mem [RS_DEPTH];

  // Stack request decoded by the arbiter, executed by the stack logic
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] push_data;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              sp_empty;
  logic              sp_full;
  logic [ADDR_W-1:0] stack_top;
  logic              accept;

  assign sp_empty  = (sp_q == '0);
  assign sp_full   = (sp_q == SP_W'(RS_DEPTH));
  assign wr_idx    = sp_q[IDX_W-1:0];
  // When full, the low index bits wrap to 0 and minus one lands on the
  // last entry, which is exactly the top of a full stack.
  assign rd_idx    = sp_q[IDX_W-1:0] - IDX_W'(1);
  assign stack_top = stack_mem[rd_idx];

  // Arbitration, winner actions and flush sequencing
  // NOTE: every signal assigned in this block gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    jump_addr_d = jump_addr_q;
    jump_flag_d = 1'b0;
    call_en_d   = 1'b0;
    hold_d      = 1'b0;
    flush_d     = 1'b0;
    req_ack_d   = 1'b0;
    irq_ack_d   = 1'b0;
    in_isr_d    = in_isr_q;
    push        = 1'b0;
    pop         = 1'b0;
    push_data   = '0;
    accept      = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (stall_req_i) begin
          // Stall blocks arbitration; requesters keep their levels up.
          hold_d = 1'b1;
        end else if (irq_req_i && !in_isr_q) begin
          accept      = 1'b1;
          push        = 1'b1;
          push_data   = pc_i;
          jump_addr_d = IRQ_VEC;
          irq_ack_d   = 1'b1;
          in_isr_d    = 1'b1;
        end else if (ret_req_i) begin
          accept      = 1'b1;
          pop         = 1'b1;
          // Underflow redirects to address 0.
          jump_addr_d = sp_empty ? '0 : stack_top;
          in_isr_d    = 1'b0;
        end else if (call_req_i) begin
          accept      = 1'b1;
          push        = 1'b1;
          push_data   = ret_addr_i;
          jump_addr_d = call_addr_i;
          call_en_d   = 1'b1;
        end else if (br_req_i) begin
          accept      = 1'b1;
          jump_addr_d = br_addr_i;
        end

        if (accept) begin
          jump_flag_d = 1'b1;
          req_ack_d   = 1'b1;
          flush_d     = 1'b1;
          cnt_d       = CNT_W'(FLUSH_CYC - 1);
          state_d     = ST_FLUSH;
        end
      end

      ST_FLUSH: begin
        // Wrong-path window: every request, stall and irq included, is
        // ignored until the counter runs out.
        if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          flush_d = 1'b1;
        end
      end

      default: state_d = ST_RUN;
    endcase
  end

  // Stack pointer update and overflow/underflow detection
  always_comb begin
    sp_d  = sp_q;
    err_d = err_q;
    wr_en = 1'b0;
    if (push) begin
      if (sp_full) begin
        // Entry dropped; the redirect itself still goes ahead.
        err_d = 1'b1;
      end else begin
        wr_en = 1'b1;
        sp_d  = sp_q + SP_W'(1);
      end
    end else if (pop) begin
      if (sp_empty) begin
        err_d = 1'b1;
      end else begin
        sp_d  = sp_q - SP_W'(1);
      end
    end
  end

  // Stack entry write
  // NOTE: the storage array has no reset; clearing the pointer is enough
  // to discard its contents, and unreset arrays map onto plain registers.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      stack_mem[wr_idx] <= push_data;
    end
  end

  // State and output registers with synchronous reset
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      sp_q        <= '0;
      jump_addr_q <= '0;
      jump_flag_q <= 1'b0;
      call_en_q   <= 1'b0;
      hold_q      <= 1'b0;
      flush_q     <= 1'b0;
      req_ack_q   <= 1'b0;
      irq_ack_q   <= 1'b0;
      in_isr_q    <= 1'b0;
      err_q       <= 1'b0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sp_q        <= sp_d;
      jump_addr_q <= jump_addr_d;
      jump_flag_q <= jump_flag_d;
      call_en_q   <= call_en_d;
      hold_q      <= hold_d;
      flush_q     <= flush_d;
      req_ack_q   <= req_ack_d;
      irq_ack_q   <= irq_ack_d;
      in_isr_q    <= in_isr_d;
      err_q       <= err_d;
      empty_q     <= (sp_d == '0);
      full_q      <= (sp_d == SP_W'(RS_DEPTH));
    end
  end

  assign jump_addr_o = jump_addr_q;
  assign jump_flag_o = jump_flag_q;
  assign call_en_o   = call_en_q;
  assign hold_flag_o = hold_q;
  assign flush_o     = flush_q;
  assign req_ack_o   = req_ack_q;
  assign irq_ack_o   = irq_ack_q;
  assign in_isr_o    = in_isr_q;
  assign rs_empty_o  = empty_q;
  assign rs_full_o   = full_q;
  assign rs_err_o    = err_q;

  // Structural invariants of the strobes
  a_jump_pulse: assert property (@(posedge clk) disable iff (rst)
    jump_flag_q |=> !jump_flag_q);
  a_hold_vs_jump: assert property (@(posedge clk) disable iff (rst)
    !(hold_q && jump_flag_q));

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: directed scenarios plus randomized traffic, checked
// every cycle against a behavioural model (queue-based return stack and a
// countdown of ignored cycles after each redirect).
module tb_pc_redirect_ctrl;

  localparam int unsigned AW        = 13;
  localparam int unsigned DEPTH     = 16;
  localparam logic [AW-1:0] VEC     = 13'h1FF0;
  localparam int unsigned FLUSH_CYC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall_req, br_req, call_req, ret_req, irq_req;
  logic [AW-1:0] br_addr, call_addr, ret_addr, pc;
  logic [AW-1:0] jump_addr;
  logic          jump_flag, call_en, hold_flag, flush, req_ack, irq_ack;
  logic          in_isr, rs_empty, rs_full, rs_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_redirect_ctrl #(
    .ADDR_W(AW), .RS_DEPTH(DEPTH), .IRQ_VEC(VEC), .FLUSH_CYC(FLUSH_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .stall_req_i(stall_req),
    .br_req_i(br_req), .br_addr_i(br_addr),
    .call_req_i(call_req), .call_addr_i(call_addr), .ret_addr_i(ret_addr),
    .ret_req_i(ret_req), .irq_req_i(irq_req), .pc_i(pc),
    .jump_addr_o(jump_addr), .jump_flag_o(jump_flag), .call_en_o(call_en),
    .hold_flag_o(hold_flag), .flush_o(flush), .req_ack_o(req_ack),
    .irq_ack_o(irq_ack), .in_isr_o(in_isr), .rs_empty_o(rs_empty),
    .rs_full_o(rs_full), .rs_err_o(rs_err)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model: expected outputs after each rising edge
  // ---------------------------------------------------------------------
  logic [AW-1:0] stk[$];
  int            ignore_left = 0;
  bit            chk_en = 1'b0;
  bit            exp_addr_chk;
  logic [AW-1:0] exp_addr;
  bit exp_jump, exp_call, exp_hold, exp_flush, exp_ack, exp_iack;
  bit exp_isr, exp_err;

  function automatic void model_push(input logic [AW-1:0] v);
    if (stk.size() == DEPTH) exp_err = 1'b1;
    else stk.push_back(v);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      stk.delete();
      ignore_left = 0;
      exp_addr = '0; exp_addr_chk = 1'b1;
      exp_jump = 0; exp_call = 0; exp_hold = 0; exp_flush = 0;
      exp_ack = 0; exp_iack = 0; exp_isr = 0; exp_err = 0;
      chk_en = 1'b1;
    end else begin
      bit won;
      exp_jump = 0; exp_call = 0; exp_hold = 0; exp_flush = 0;
      exp_ack = 0; exp_iack = 0; exp_addr_chk = 1'b0;
      won = 1'b0;
      if (ignore_left > 0) begin
        ignore_left--;
        exp_flush = (ignore_left > 0);
      end else if (stall_req) begin
        exp_hold = 1'b1;
      end else begin
        won = 1'b1;
        if (irq_req && !exp_isr) begin
          model_push(pc);
          exp_addr = VEC; exp_iack = 1'b1; exp_isr = 1'b1;
        end else if (ret_req) begin
          if (stk.size() == 0) begin
            exp_addr = '0; exp_err = 1'b1;
          end else begin
            exp_addr = stk.pop_back();
          end
          exp_isr = 1'b0;
        end else if (call_req) begin
          model_push(ret_addr);
          exp_addr = call_addr; exp_call = 1'b1;
        end else if (br_req) begin
          exp_addr = br_addr;
        end else begin
          won = 1'b0;
        end
        if (won) begin
          exp_jump = 1; exp_ack = 1; exp_flush = 1; exp_addr_chk = 1;
          ignore_left = FLUSH_CYC;
        end
      end
    end
  end

  // Compare process: DUT against model on every falling edge
  logic prev_jump = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("jump_flag", 32'(jump_flag), 32'(exp_jump));
      check("call_en",   32'(call_en),   32'(exp_call));
      check("hold_flag", 32'(hold_flag), 32'(exp_hold));
      check("flush",     32'(flush),     32'(exp_flush));
      check("req_ack",   32'(req_ack),   32'(exp_ack));
      check("irq_ack",   32'(irq_ack),   32'(exp_iack));
      check("in_isr",    32'(in_isr),    32'(exp_isr));
      check("rs_err",    32'(rs_err),    32'(exp_err));
      check("rs_empty",  32'(rs_empty),  32'(stk.size() == 0));
      check("rs_full",   32'(rs_full),   32'(stk.size() == DEPTH));
      if (exp_addr_chk) check("jump_addr", 32'(jump_addr), 32'(exp_addr));
      check("jump_not_back_to_back", 32'(prev_jump & jump_flag), 32'd0);
      check("hold_with_jump", 32'(hold_flag & jump_flag), 32'd0);
      prev_jump = jump_flag;
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    stall_req = 0; br_req = 0; call_req = 0; ret_req = 0; irq_req = 0;
  endtask

  // Leave the flush window with all requests down
  task automatic settle();
    clear_reqs();
    repeat (FLUSH_CYC) step();
  endtask

  initial begin
    rst = 1'b1;
    clear_reqs();
    br_addr = '0; call_addr = '0; ret_addr = '0; pc = '0;
    step(); step();
    rst = 1'b0;

    // Reset state
    check("rst_jump_addr", 32'(jump_addr), 32'h0);
    check("rst_flush",     32'(flush),     32'h0);
    check("rst_empty",     32'(rs_empty),  32'h1);
    check("rst_full",      32'(rs_full),   32'h0);
    check("rst_err",       32'(rs_err),    32'h0);

    // Single branch and its flush window
    br_req = 1; br_addr = 13'h0123;
    step();
    br_req = 0;
    check("br_jump",  32'(jump_flag), 32'h1);
    check("br_addr",  32'(jump_addr), 32'h0123);
    check("br_ack",   32'(req_ack),   32'h1);
    check("br_flush1", 32'(flush),    32'h1);
    step();
    check("br_flush2", 32'(flush),    32'h1);
    step();
    check("br_flush_end", 32'(flush), 32'h0);

    // Call then return
    call_req = 1; call_addr = 13'h0400; ret_addr = 13'h0011;
    step();
    check("call_addr", 32'(jump_addr), 32'h0400);
    check("call_en",   32'(call_en),   32'h1);
    settle();
    ret_req = 1;
    step();
    check("ret_addr",  32'(jump_addr), 32'h0011);
    check("ret_empty", 32'(rs_empty),  32'h1);
    check("ret_err",   32'(rs_err),    32'h0);
    settle();

    // irq beats ret beats br
    irq_req = 1; ret_req = 1; br_req = 1; pc = 13'h0050; br_addr = 13'h0200;
    step();
    irq_req = 0;
    check("irq_addr", 32'(jump_addr), 32'h1FF0);
    check("irq_ack",  32'(irq_ack),   32'h1);
    check("irq_isr",  32'(in_isr),    32'h1);
    step(); step();
    check("irq_no_early_jump", 32'(jump_flag), 32'h0);
    step();
    ret_req = 0;
    check("isr_ret_addr", 32'(jump_addr), 32'h0050);
    check("isr_ret_isr",  32'(in_isr),    32'h0);
    step(); step();
    step();
    br_req = 0;
    check("post_isr_br",  32'(jump_addr), 32'h0200);
    check("post_isr_jmp", 32'(jump_flag), 32'h1);
    settle();

    // Stall holds a pending branch for three cycles
    stall_req = 1; br_req = 1; br_addr = 13'h0333;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold",   32'(hold_flag), 32'h1);
      check("stall_nojump", 32'(jump_flag), 32'h0);
    end
    stall_req = 0;
    step();
    br_req = 0;
    check("unstall_jump", 32'(jump_flag), 32'h1);
    check("unstall_addr", 32'(jump_addr), 32'h0333);
    check("unstall_hold", 32'(hold_flag), 32'h0);
    settle();

    // Overflow with 17 calls, underflow with 17 returns
    for (int i = 0; i < 17; i++) begin
      call_req = 1; call_addr = AW'(13'h0100 + i); ret_addr = AW'(13'h0020 + i);
      step();
      check("ovf_jump", 32'(jump_flag), 32'h1);
      if (i == 15) begin
        check("ovf_full16", 32'(rs_full), 32'h1);
        check("ovf_err16",  32'(rs_err),  32'h0);
      end
      if (i == 16) begin
        check("ovf_err17",  32'(rs_err),    32'h1);
        check("ovf_addr17", 32'(jump_addr), 32'h0110);
      end
      settle();
    end
    for (int i = 0; i < 17; i++) begin
      ret_req = 1;
      step();
      if (i < 16) check("pop_order", 32'(jump_addr), 32'h0020 + 32'(15 - i));
      else begin
        check("underflow_addr",  32'(jump_addr), 32'h0);
        check("underflow_empty", 32'(rs_empty),  32'h1);
      end
      settle();
    end

    // Reset during flush with three stacked entries
    for (int i = 0; i < 3; i++) begin
      call_req = 1; call_addr = AW'(13'h0500 + i); ret_addr = AW'(13'h0030 + i);
      step();
      settle();
    end
    br_req = 1; br_addr = 13'h0600;
    step();
    br_req = 0; rst = 1;
    step();
    rst = 0;
    check("rstf_flush", 32'(flush),    32'h0);
    check("rstf_empty", 32'(rs_empty), 32'h1);
    check("rstf_err",   32'(rs_err),   32'h0);
    br_req = 1; br_addr = 13'h0777;
    step();
    br_req = 0;
    check("rstf_run_jump", 32'(jump_flag), 32'h1);
    check("rstf_run_addr", 32'(jump_addr), 32'h0777);
    settle();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rst       = ($urandom_range(0, 299) == 0);
      stall_req = ($urandom_range(0, 4) == 0);
      br_req    = ($urandom_range(0, 4) < 2);
      call_req  = ($urandom_range(0, 3) == 0);
      ret_req   = ($urandom_range(0, 3) == 0);
      irq_req   = ($urandom_range(0, 9) == 0);
      br_addr   = AW'($urandom_range(0, 8191));
      call_addr = AW'($urandom_range(0, 8191));
      ret_addr  = AW'($urandom_range(0, 8191));
      pc        = AW'($urandom_range(0, 8191));
      step();
    end
    rst = 0;
    clear_reqs();
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
- Sequencing controller for the 13-bit program counter.
- Collects redirect requests (branch, call, return, interrupt) and stall requests from the pipeline, arbitrates them, and drives the PC block's jump_addr/jump_flag/call_en/hold_flag inputs.
- Owns the hardware return-address stack and post-redirect flush timing.

Parameters:
ADDR_W, 13, PC/address width
RS_DEPTH, 16, return-stack entries (power of 2, >=2)
IRQ_VEC, 13'h1FF0, interrupt vector address
FLUSH_CYC, 2, cycles flush_o stays high after any redirect (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
stall_req_i  in  1  pipeline stall request (level)
br_req_i  in  1  taken branch/jump request (level, held until accepted)
br_addr_i  in  ADDR_W  branch target
call_req_i  in  1  call request (level)
call_addr_i  in  ADDR_W  call target
ret_addr_i  in  ADDR_W  return address to push on call (PC+1 of call)
ret_req_i  in  1  return request (level)
irq_req_i  in  1  interrupt request (level)
pc_i  in  ADDR_W  current PC, pushed on interrupt entry
jump_addr_o  out  ADDR_W  redirect target to PC
jump_flag_o  out  1  redirect strobe to PC
call_en_o  out  1  call strobe to PC
hold_flag_o  out  1  pipeline hold to PC
flush_o  out  1  squash fetched/decoded instructions
req_ack_o  out  1  one-cycle pulse: a redirect request was accepted
irq_ack_o  out  1  one-cycle pulse: interrupt taken
in_isr_o  out  1  interrupt service in progress
rs_empty_o  out  1  return stack empty
rs_full_o  out  1  return stack holds RS_DEPTH entries
rs_err_o  out  1  sticky overflow/underflow flag

Behaviour:
- Reset (rst=1 at clk edge): state=RUN; all strobes, hold_flag_o, flush_o, in_isr_o, rs_err_o = 0; jump_addr_o = 0; stack pointer = 0; rs_empty_o = 1; rs_full_o = 0. Reset mid-flush or mid-stall aborts immediately; stack contents are discarded.
- All outputs are registered. A request accepted in cycle N produces jump_flag_o/jump_addr_o/req_ack_o in cycle N+1.
- State RUN:
  - stall_req_i=1: hold_flag_o=1 next cycle and no request is accepted. Requesters keep their requests asserted.
  - stall_req_i=0: arbitrate with fixed priority irq > ret > call > br.
  - irq is eligible only when in_isr_o=0.
  - One winner per cycle; losers are not acknowledged and must stay asserted.
  - Any acceptance moves to FLUSH.
- Winner actions:
  - irq: push pc_i; jump_addr_o=IRQ_VEC; jump_flag_o=1; irq_ack_o=1; in_isr_o set.
  - ret: pop; jump_addr_o=popped value; jump_flag_o=1; in_isr_o cleared.
  - call: push ret_addr_i; jump_addr_o=call_addr_i; jump_flag_o=1; call_en_o=1.
  - br: jump_addr_o=br_addr_i; jump_flag_o=1.
- State FLUSH:
  - flush_o=1 for exactly FLUSH_CYC cycles, starting the cycle jump_flag_o is high.
  - All requests ignored, including stall and irq (wrong-path), then return to RUN.
  - A request still asserted on the return to RUN is arbitrated normally.
- Return stack (LIFO, RS_DEPTH x ADDR_W, registers):
  - Push when full: entry dropped, pointer unchanged, rs_err_o set; redirect still performed.
  - Pop when empty: jump_addr_o=0, rs_err_o set, pointer stays 0.
  - rs_err_o clears only on reset.
  - rs_empty_o/rs_full_o reflect the pointer after the update (registered).
- jump_flag_o, call_en_o, req_ack_o and irq_ack_o are single-cycle pulses; never high two consecutive cycles.
- hold_flag_o is never high in the same cycle as jump_flag_o.

Test Plan:
- Reset then br_req_i=1, br_addr_i=13'h0123 for one cycle -> next cycle jump_flag_o=1, jump_addr_o=13'h0123, req_ack_o=1; flush_o high 2 cycles; back in RUN on 3rd cycle.
- call (call_addr_i=13'h0400, ret_addr_i=13'h0011), then after flush ret_req_i -> jump_addr_o=13'h0400 with call_en_o=1, then jump_addr_o=13'h0011; rs_empty_o=1 at end; rs_err_o=0.
- irq_req_i, ret_req_i, br_req_i all high same cycle, pc_i=13'h0050 -> irq wins: jump_addr_o=13'h1FF0, irq_ack_o=1, in_isr_o=1. After flush, ret wins over br, jump_addr_o=13'h0050, in_isr_o=0. After next flush, br accepted.
- stall_req_i high 3 cycles with br_req_i held -> hold_flag_o=1 for 3 cycles, no jump_flag_o; branch accepted the cycle stall drops.
- 17 calls with RS_DEPTH=16 -> rs_full_o=1 after 16th, 17th sets rs_err_o but still redirects. 17 returns: 16 pop in reverse order, 17th gives jump_addr_o=0.
- Assert rst during FLUSH with 3 entries on stack -> next cycle flush_o=0, rs_empty_o=1, rs_err_o=0, state RUN.
